// File: rtl/pwm_multi_ch_if.sv
// Control/status bundle for pwm_multi_ch: run enable, period/duty requests and PWM outputs.
interface pwm_multi_ch_if #(
  parameter int CH = 4,
  parameter int CW = 16
);
  logic             iEnable;
  logic [CW-1:0]    iPeriod;
  logic [CH*CW-1:0] iDuty;
  logic             iLoad;
  logic [CH-1:0]    oPwm;
  logic             oPeriodEnd;
  logic             oLoadDone;

  modport master (
    output iEnable, iPeriod, iDuty, iLoad,
    input  oPwm, oPeriodEnd, oLoadDone
  );

  modport slave (
    input  iEnable, iPeriod, iDuty, iLoad,
    output oPwm, oPeriodEnd, oLoadDone
  );
endinterface

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM with one shared counter and double-buffered period/duty applied at period boundaries.
// Define PWM_CENTER_ALIGN_EN for up/down (center-aligned) counting; default is edge-aligned.
module pwm_multi_ch #(
  parameter int CH = 4,
  parameter int CW = 16
) (
  input  logic          iClk,
  input  logic          iReset_n,
  pwm_multi_ch_if.slave bus
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] per_act_q, per_act_d;
  logic [CW-1:0] per_sh_q, per_sh_d;
  logic [CW-1:0] duty_act_q [CH];
  logic [CW-1:0] duty_act_d [CH];
  logic [CW-1:0] duty_sh_q [CH];
  logic [CW-1:0] duty_sh_d [CH];
  logic          pending_q, pending_d;
  logic [CH-1:0] pwm_q, pwm_d;
  logic          period_end_q, period_end_d;
  logic          load_done_q, load_done_d;
`ifdef PWM_CENTER_ALIGN_EN
  logic          dir_q, dir_d;
`endif

  logic [CW-1:0] eff_per;
  logic [CW-1:0] last;
  logic          boundary;

  always_comb begin
    eff_per = (per_act_q == '0) ? CW'(1) : per_act_q;
    last    = eff_per - CW'(1);
    cnt_d   = '0;
`ifdef PWM_CENTER_ALIGN_EN
    dir_d    = 1'b0;
    // Period 1 degenerates to a counter parked at 0 with every clock a boundary.
    boundary = bus.iEnable && ((last == '0) || (dir_q && (cnt_q == '0)));
    if (bus.iEnable && (last != '0)) begin
      if (!dir_q) begin
        dir_d = (cnt_q == last);
        cnt_d = (cnt_q == last) ? cnt_q : cnt_q + CW'(1);
      end else begin
        dir_d = (cnt_q != '0);
        cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
      end
    end
`else
    boundary = bus.iEnable && (cnt_q == last);
    if (bus.iEnable && !boundary) begin
      cnt_d = cnt_q + CW'(1);
    end
`endif

    for (int i = 0; i < CH; i++) begin
      pwm_d[i] = bus.iEnable && (cnt_q < duty_act_q[i]);
    end
    period_end_d = boundary;

    per_sh_d    = per_sh_q;
    duty_sh_d   = duty_sh_q;
    per_act_d   = per_act_q;
    duty_act_d  = duty_act_q;
    pending_d   = pending_q;
    load_done_d = 1'b0;
    // A strobe on the apply cycle wins: it refreshes the shadow and defers the apply.
    if (bus.iLoad) begin
      per_sh_d  = bus.iPeriod;
      for (int i = 0; i < CH; i++) begin
        duty_sh_d[i] = bus.iDuty[i*CW +: CW];
      end
      pending_d = 1'b1;
    end else if (pending_q && (boundary || !bus.iEnable)) begin
      per_act_d   = per_sh_q;
      duty_act_d  = duty_sh_q;
      pending_d   = 1'b0;
      load_done_d = 1'b1;
    end
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      cnt_q        <= '0;
      per_act_q    <= '0;
      per_sh_q     <= '0;
      pending_q    <= 1'b0;
      pwm_q        <= '0;
      period_end_q <= 1'b0;
      load_done_q  <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        duty_act_q[i] <= '0;
        duty_sh_q[i]  <= '0;
      end
`ifdef PWM_CENTER_ALIGN_EN
      dir_q        <= 1'b0;
`endif
    end else begin
      cnt_q        <= cnt_d;
      per_act_q    <= per_act_d;
      per_sh_q     <= per_sh_d;
      pending_q    <= pending_d;
      pwm_q        <= pwm_d;
      period_end_q <= period_end_d;
      load_done_q  <= load_done_d;
      for (int i = 0; i < CH; i++) begin
        duty_act_q[i] <= duty_act_d[i];
        duty_sh_q[i]  <= duty_sh_d[i];
      end
`ifdef PWM_CENTER_ALIGN_EN
      dir_q        <= dir_d;
`endif
    end
  end

  assign bus.oPwm       = pwm_q;
  assign bus.oPeriodEnd = period_end_q;
  assign bus.oLoadDone  = load_done_q;

endmodule
